// File: rtl/div_fu_ctrl.sv
// Divide FU controller: runs DIV/DIVU/REM/REMU on a 33-bit signed
// sequential divider and holds the 32-bit result for the CDB.
module div_fu_ctrl #(
  parameter int ROB_IDX_W  = 5,
  parameter int PREG_IDX_W = 6,
  parameter int DIV_CYCLES = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  iss_valid,
  output logic                  iss_ready,
  input  logic [1:0]            iss_op,
  input  logic [31:0]           iss_rs1_v,
  input  logic [31:0]           iss_rs2_v,
  input  logic [ROB_IDX_W-1:0]  iss_rob_id,
  input  logic [PREG_IDX_W-1:0] iss_pd,
  output logic                  div_start,
  output logic [32:0]           div_a,
  output logic [32:0]           div_b,
  input  logic                  div_complete,
  input  logic [32:0]           div_quotient,
  input  logic [32:0]           div_remainder,
  output logic                  cdb_valid,
  input  logic                  cdb_ready,
  output logic [ROB_IDX_W-1:0]  cdb_rob_id,
  output logic [PREG_IDX_W-1:0] cdb_pd,
  output logic [31:0]           cdb_data
);

  localparam int CNT_W = $clog2(DIV_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             rem_q;
  logic             accept;
  logic             is_signed;
  logic             b_zero;
  logic [32:0]      a_ext;
  logic [32:0]      b_ext;
  logic             unused_hi;

  assign iss_ready = !rst && !flush &&
    (state == IDLE || (state == DONE && cdb_ready));
  assign accept    = iss_valid && iss_ready;
  assign is_signed = !iss_op[0];
  assign b_zero    = (iss_rs2_v == 32'd0);
  assign a_ext     = {is_signed & iss_rs1_v[31], iss_rs1_v};
  assign b_ext     = {is_signed & iss_rs2_v[31], iss_rs2_v};

  // Bit 32 of the results is dropped: RISC-V keeps the low word.
  assign unused_hi = ^{div_quotient[32], div_remainder[32]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      rem_q      <= 1'b0;
      div_start  <= 1'b0;
      div_a      <= '0;
      div_b      <= '0;
      cdb_valid  <= 1'b0;
      cdb_data   <= '0;
      cdb_rob_id <= '0;
      cdb_pd     <= '0;
    end else if (flush) begin
      state     <= IDLE;
      div_start <= 1'b0;
      cdb_valid <= 1'b0;
    end else if (accept) begin
      rem_q      <= iss_op[1];
      div_a      <= a_ext;
      div_b      <= b_ext;
      cdb_rob_id <= iss_rob_id;
      cdb_pd     <= iss_pd;
      if (b_zero) begin
        state     <= DONE;
        div_start <= 1'b0;
        cdb_valid <= 1'b1;
        cdb_data  <= iss_op[1] ? iss_rs1_v : 32'hFFFF_FFFF;
      end else begin
        state     <= START;
        div_start <= 1'b1;
        cdb_valid <= 1'b0;
      end
    end else begin
      div_start <= 1'b0;
      unique case (state)
        IDLE: ;
        START: begin
          cnt   <= CNT_W'(DIV_CYCLES);
          state <= RUN;
        end
        RUN: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else if (div_complete) begin
            cdb_data  <= rem_q ? div_remainder[31:0]
                               : div_quotient[31:0];
            cdb_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (cdb_ready) begin
            cdb_valid <= 1'b0;
            state     <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_fu_ctrl.sv
// Bench for div_fu_ctrl: divider model, scoreboard queue and monitor,
// directed timing cases then randomized traffic.
module tb_div_fu_ctrl;

  localparam int RW = 5;
  localparam int PW = 6;
  localparam int NC = 9;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          iss_valid = 1'b0;
  logic          iss_ready;
  logic [1:0]    iss_op = '0;
  logic [31:0]   iss_rs1_v = '0;
  logic [31:0]   iss_rs2_v = '0;
  logic [RW-1:0] iss_rob_id = '0;
  logic [PW-1:0] iss_pd = '0;
  logic          div_start;
  logic [32:0]   div_a;
  logic [32:0]   div_b;
  logic          div_complete = 1'b0;
  logic [32:0]   div_quotient = '0;
  logic [32:0]   div_remainder = '0;
  logic          cdb_valid;
  logic          cdb_ready = 1'b0;
  logic [RW-1:0] cdb_rob_id;
  logic [PW-1:0] cdb_pd;
  logic [31:0]   cdb_data;

  div_fu_ctrl #(
    .ROB_IDX_W (RW),
    .PREG_IDX_W(PW),
    .DIV_CYCLES(NC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .iss_valid    (iss_valid),
    .iss_ready    (iss_ready),
    .iss_op       (iss_op),
    .iss_rs1_v    (iss_rs1_v),
    .iss_rs2_v    (iss_rs2_v),
    .iss_rob_id   (iss_rob_id),
    .iss_pd       (iss_pd),
    .div_start    (div_start),
    .div_a        (div_a),
    .div_b        (div_b),
    .div_complete (div_complete),
    .div_quotient (div_quotient),
    .div_remainder(div_remainder),
    .cdb_valid    (cdb_valid),
    .cdb_ready    (cdb_ready),
    .cdb_rob_id   (cdb_rob_id),
    .cdb_pd       (cdb_pd),
    .cdb_data     (cdb_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [RW-1:0] rob;
    logic [PW-1:0] pd;
    logic [31:0]   data;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   rdy_mode = 0;
  int   extra = 0;
  int   dcnt = 0;
  int   tag = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // RISC-V divide semantics in plain 64-bit arithmetic.
  function automatic logic [31:0] ref_model(input logic [1:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
    longint x;
    longint y;
    longint r;
    x = op[0] ? longint'(a) : longint'(int'(a));
    y = op[0] ? longint'(b) : longint'(int'(b));
    if (y == 0) r = op[1] ? x : -1;
    else r = op[1] ? (x % y) : (x / y);
    return r[31:0];
  endfunction

  // Sequential divider: registered inputs, fixed latency plus slack.
  always @(posedge clk) begin
    if (div_start) begin
      div_quotient  <= 33'($signed(div_a) / $signed(div_b));
      div_remainder <= 33'($signed(div_a) % $signed(div_b));
      dcnt          <= NC + extra;
      div_complete  <= 1'b0;
    end else if (dcnt > 1) begin
      dcnt <= dcnt - 1;
    end else if (dcnt == 1) begin
      dcnt         <= 0;
      div_complete <= 1'b1;
    end
  end

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       cdb_ready = 1'b0;
      1:       cdb_ready = 1'b1;
      default: cdb_ready = ($urandom_range(0, 9) < 7);
    endcase
  end

  logic          held_v = 1'b0;
  logic [RW-1:0] h_rob;
  logic [PW-1:0] h_pd;
  logic [31:0]   h_data;

  always @(negedge clk) begin
    if (!rst) begin
      if (held_v)
        chk("cdb_hold", {cdb_valid, cdb_rob_id, cdb_pd, cdb_data},
            {1'b1, h_rob, h_pd, h_data});
      if (cdb_valid && cdb_ready) begin
        if (sbq.size() == 0) begin
          chk("cdb_unexpected", {63'd0, cdb_valid}, 64'd0);
        end else begin
          mon_e = sbq.pop_front();
          chk("cdb_result", {cdb_rob_id, cdb_pd, cdb_data},
              {mon_e.rob, mon_e.pd, mon_e.data});
        end
      end
      held_v = cdb_valid && !cdb_ready && !flush;
      h_rob  = cdb_rob_id;
      h_pd   = cdb_pd;
      h_data = cdb_data;
    end else begin
      held_v = 1'b0;
    end
  end

  task automatic issue(input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, output int waits);
    exp_t e;
    @(posedge clk);
    #1;
    iss_valid  = 1'b1;
    iss_op     = op;
    iss_rs1_v  = a;
    iss_rs2_v  = b;
    iss_rob_id = RW'(tag);
    iss_pd     = PW'(tag * 7 + 3);
    tag++;
    waits = 0;
    forever begin
      @(negedge clk);
      if (iss_ready) break;
      waits++;
      if (waits > 300) break;
    end
    if (waits > 300) begin
      chk("issue_timeout", {63'd0, iss_ready}, 64'd1);
    end else begin
      e.rob  = iss_rob_id;
      e.pd   = iss_pd;
      e.data = ref_model(op, a, b);
      sbq.push_back(e);
    end
    @(posedge clk);
    #1;
    iss_valid = 1'b0;
  endtask

  task automatic timed(input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input string name);
    int          w;
    bit          z;
    logic [32:0] ea;
    logic [32:0] eb;
    z  = (b == 32'd0);
    ea = {!op[0] && a[31], a};
    eb = {!op[0] && b[31], b};
    issue(op, a, b, w);
    for (int k = 1; k <= (z ? 1 : 12); k++) begin
      @(negedge clk);
      if (k == 1) begin
        chk({name, " start"}, {63'd0, div_start}, {63'd0, !z});
        chk({name, " valid_t1"}, {63'd0, cdb_valid}, {63'd0, z});
        if (!z) begin
          chk({name, " div_a"}, {31'd0, div_a}, {31'd0, ea});
          chk({name, " div_b"}, {31'd0, div_b}, {31'd0, eb});
        end
      end
      if (k == 2) chk({name, " start_off"}, {63'd0, div_start}, 64'd0);
      if (k == 11) chk({name, " valid_t11"}, {63'd0, cdb_valid}, 64'd0);
      if (k == 12) chk({name, " valid_t12"}, {63'd0, cdb_valid}, 64'd1);
    end
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk(name, 64'(sbq.size()), 64'd0);
  endtask

  task automatic kill(input bit use_rst, input string name);
    int w;
    bit bad;
    rdy_mode = 1;
    extra    = 0;
    issue(2'b00, 32'd1000, 32'd7, w);
    repeat (6) @(negedge clk);
    @(posedge clk);
    #1;
    if (use_rst) rst = 1'b1;
    else flush = 1'b1;
    iss_valid = 1'b1;
    iss_op    = 2'b11;
    iss_rs1_v = 32'd9;
    iss_rs2_v = 32'd4;
    @(negedge clk);
    chk({name, " iss_ready"}, {63'd0, iss_ready}, 64'd0);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    flush     = 1'b0;
    iss_valid = 1'b0;
    if (sbq.size() != 0) sbq.delete(sbq.size() - 1);
    @(negedge clk);
    chk({name, " out_off"}, {62'd0, cdb_valid, div_start}, 64'd0);
    if (use_rst) begin
      chk({name, " regs"}, {21'd0, cdb_rob_id, cdb_pd, cdb_data}, 64'd0);
      chk({name, " div_a"}, {31'd0, div_a}, 64'd0);
      chk({name, " div_b"}, {31'd0, div_b}, 64'd0);
      chk({name, " ready"}, {63'd0, iss_ready}, 64'd1);
    end
    bad = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (cdb_valid || div_start) bad = 1'b1;
    end
    chk({name, " quiet"}, {63'd0, bad}, 64'd0);
    timed(2'b10, 32'hFFFF_FF9C, 32'd7, {name, " next"});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int          w;
    int          n;
    int          sel;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [43:0] snap;

    repeat (3) @(negedge clk);
    chk("rst iss_ready", {63'd0, iss_ready}, 64'd0);
    chk("rst outs", {22'd0, div_start, cdb_valid, cdb_rob_id, cdb_pd,
        cdb_data}, 64'd0);
    chk("rst div_a", {31'd0, div_a}, 64'd0);
    chk("rst div_b", {31'd0, div_b}, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst iss_ready", {63'd0, iss_ready}, 64'd1);

    rdy_mode = 1;
    timed(2'b00, 32'hFFFF_FFF9, 32'd2, "div_neg");
    timed(2'b10, 32'hFFFF_FFF9, 32'd2, "rem_neg");
    timed(2'b01, 32'hFFFF_FFFF, 32'd2, "divu_big");
    timed(2'b11, 32'd7, 32'd3, "remu_small");
    timed(2'b00, 32'd5, 32'd0, "div_zero");
    timed(2'b11, 32'd5, 32'd0, "remu_zero");
    timed(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    timed(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf");
    drain("directed drain");

    rdy_mode = 0;
    issue(2'b01, 32'd1000, 32'd7, w);
    n = 0;
    while (!cdb_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("bp valid", {63'd0, cdb_valid}, 64'd1);
    snap = {cdb_valid, cdb_rob_id, cdb_pd, cdb_data};
    repeat (5) begin
      @(negedge clk);
      chk("bp stable", {20'd0, cdb_valid, cdb_rob_id, cdb_pd, cdb_data},
          {20'd0, snap});
    end
    rdy_mode = 1;
    issue(2'b00, 32'hFFFF_FF9C, 32'd7, w);
    chk("b2b wait", 64'(w), 64'd0);
    @(negedge clk);
    chk("b2b start", {63'd0, div_start}, 64'd1);
    drain("b2b drain");

    kill(1'b0, "flush");
    kill(1'b1, "rst_mid");
    drain("kill drain");

    rdy_mode = 2;
    for (int i = 0; i < 60; i++) begin
      op  = 2'($urandom_range(0, 3));
      sel = $urandom_range(0, 7);
      a   = $urandom;
      b   = $urandom;
      if (sel == 0) begin
        b = 32'd0;
      end else if (sel == 1) begin
        a = 32'h8000_0000;
        b = 32'hFFFF_FFFF;
      end else if (sel == 2) begin
        a = 32'($urandom_range(0, 40)) - 32'd20;
        b = 32'($urandom_range(0, 10)) - 32'd5;
      end
      extra = $urandom_range(0, 3);
      issue(op, a, b, w);
    end
    rdy_mode = 1;
    drain("random drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
